add64_seq_ctrl: RTL and testbench

Sequencing wrapper that sits directly upstream and downstream of the 64-bit carry-lookahead adder datapath. It accepts operand transactions over a valid/ready handshake and registers the operands to drive the adder's a/b/cin inputs. It waits a fixed number of settle cycles for the combinational carry chain, then captures s/cout together with derived flags into a result register with its own valid/ready handshake. It also supports subtraction by inverting b and forcing carry-in.

---
 rtl/add64_seq_ctrl_if.sv | 40 ++++
 rtl/add64_seq_ctrl.sv | 108 ++++++++++
 tb/tb_add64_seq_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/add64_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : add64_seq_ctrl_if
// Brief    : Operand, adder-port and result handshake bundle for add64_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface add64_seq_ctrl_if #(
    parameter int N = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic         add_cin;
    logic [N-1:0] add_s;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, add_s, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout,
               out_ovf, out_zero
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, add_s, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout,
               out_ovf, out_zero
    );
endinterface
`default_nettype wire

// File: rtl/add64_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : add64_seq_ctrl
// Brief    : Registers operands for the CLA adder, waits out the carry settle
//            time, then captures sum and flags behind a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module add64_seq_ctrl #(
    parameter int N             = 64,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    add64_seq_ctrl_if.slave       bus,
    output logic      [CNT_W-1:0] op_count
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETTLE = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;
    localparam logic [3:0] c_LOAD   = 4'(SETTLE_CYCLES - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [3:0]       r_settle;
    logic [N-1:0]     r_add_a;
    logic [N-1:0]     r_add_b;
    logic             r_add_cin;
    logic [N-1:0]     r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic [CNT_W-1:0] r_op_count;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_capture;
    logic             w_handshake;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   if (bus.in_valid)     w_next_state = c_SETTLE;
            c_SETTLE: if (r_settle == 4'd0) w_next_state = c_DONE;
            c_DONE:   if (bus.out_ready)    w_next_state = c_IDLE;
            default:                        w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = (r_state == c_IDLE);
        w_out_valid = (r_state == c_DONE);
    end

    assign w_accept    = w_in_ready && bus.in_valid;
    assign w_capture   = (r_state == c_SETTLE) && (r_settle == 4'd0);
    assign w_handshake = w_out_valid && bus.out_ready;

    // Subtraction is A + ~B + 1, so the adder itself never needs to know.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_add_a    <= '0;
            r_add_b    <= '0;
            r_add_cin  <= 1'b0;
            r_settle   <= 4'd0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (w_accept) begin
                r_add_a   <= bus.in_a;
                r_add_b   <= bus.in_sub ? ~bus.in_b : bus.in_b;
                r_add_cin <= bus.in_sub ? 1'b1 : bus.in_cin;
                r_settle  <= c_LOAD;
            end else if ((r_state == c_SETTLE) && (r_settle != 4'd0)) begin
                r_settle <= r_settle - 4'd1;
            end
            if (w_capture) begin
                r_sum  <= bus.add_s;
                r_cout <= bus.add_cout;
                r_ovf  <= (r_add_a[N-1] == r_add_b[N-1]) && (bus.add_s[N-1] != r_add_a[N-1]);
                r_zero <= (bus.add_s == '0);
            end
            if (w_handshake) r_op_count <= r_op_count + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.add_a     = r_add_a;
    assign bus.add_b     = r_add_b;
    assign bus.add_cin   = r_add_cin;
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;
    assign bus.out_ovf   = r_ovf;
    assign bus.out_zero  = r_zero;
    assign op_count      = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_add64_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_add64_seq_ctrl
// Brief    : Directed bench for add64_seq_ctrl with a behavioural adder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add64_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n0 = 1'b0;
    logic        rst_n1 = 1'b0;
    logic [15:0] op_count0;
    logic [3:0]  op_count1;
    int          n_assert = 0;
    int          n_fail   = 0;

    add64_seq_ctrl_if #(.N(64)) bus0 ();
    add64_seq_ctrl_if #(.N(64)) bus1 ();

    add64_seq_ctrl #(.N(64), .SETTLE_CYCLES(2), .CNT_W(16)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n0),
        .bus      (bus0),
        .op_count (op_count0)
    );

    add64_seq_ctrl #(.N(64), .SETTLE_CYCLES(5), .CNT_W(4)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n1),
        .bus      (bus1),
        .op_count (op_count1)
    );

    // Behavioural stand-in for the carry-lookahead adder.
    assign {bus0.add_cout, bus0.add_s} = {1'b0, bus0.add_a} + {1'b0, bus0.add_b} + 65'(bus0.add_cin);
    assign {bus1.add_cout, bus1.add_s} = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + 65'(bus1.add_cin);

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
        bus0.in_a     = a;
        bus0.in_b     = b;
        bus0.in_cin   = cin;
        bus0.in_sub   = sub;
        bus0.in_valid = 1'b1;
    endtask

    task automatic handshake0(input logic [15:0] exp_cnt);
        bus0.out_ready = 1'b1;
        tick();
        bus0.out_ready = 1'b0;
        chk("hs_op_count", op_count0, exp_cnt);
        chk("hs_out_valid", bus0.out_valid, 0);
        chk("hs_in_ready", bus0.in_ready, 1);
    endtask

    initial begin
        bus0.in_valid = 0; bus0.in_a = '0; bus0.in_b = '0; bus0.in_cin = 0; bus0.in_sub = 0;
        bus0.out_ready = 0;
        bus1.in_valid = 0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 0; bus1.in_sub = 0;
        bus1.out_ready = 1;

        // Reset state
        repeat (2) tick();
        chk("rst_in_ready", bus0.in_ready, 1);
        chk("rst_out_valid", bus0.out_valid, 0);
        chk("rst_add_a", bus0.add_a, 0);
        chk("rst_add_b", bus0.add_b, 0);
        chk("rst_out_sum", bus0.out_sum, 0);
        chk("rst_op_count", op_count0, 0);
        rst_n0 = 1'b1;
        rst_n1 = 1'b1;
        tick();

        // 1: all-ones + 1, capture two edges after accept
        drive0(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        tick();
        bus0.in_valid = 0;
        chk("t1_add_a", bus0.add_a, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_add_b", bus0.add_b, 64'd1);
        chk("t1_add_cin", bus0.add_cin, 0);
        chk("t1_in_ready_busy", bus0.in_ready, 0);
        tick();
        chk("t1_valid_early", bus0.out_valid, 0);
        tick();
        chk("t1_out_valid", bus0.out_valid, 1);
        chk("t1_sum", bus0.out_sum, 64'd0);
        chk("t1_cout", bus0.out_cout, 1);
        chk("t1_zero", bus0.out_zero, 1);
        chk("t1_ovf", bus0.out_ovf, 0);
        handshake0(16'd1);
        chk("t1_sum_held", bus0.out_sum, 64'd0);
        chk("t1_zero_held", bus0.out_zero, 1);

        // 2: 5 - 7
        drive0(64'd5, 64'd7, 1'b0, 1'b1);
        tick();
        bus0.in_valid = 0;
        chk("t2_add_b", bus0.add_b, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("t2_add_cin", bus0.add_cin, 1);
        repeat (2) tick();
        chk("t2_out_valid", bus0.out_valid, 1);
        chk("t2_sum", bus0.out_sum, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("t2_cout", bus0.out_cout, 0);
        chk("t2_ovf", bus0.out_ovf, 0);
        chk("t2_zero", bus0.out_zero, 0);
        handshake0(16'd2);

        // 3: signed overflow
        drive0(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        tick();
        bus0.in_valid = 0;
        repeat (2) tick();
        chk("t3_sum", bus0.out_sum, 64'h8000_0000_0000_0000);
        chk("t3_ovf", bus0.out_ovf, 1);
        chk("t3_cout", bus0.out_cout, 0);
        chk("t3_zero", bus0.out_zero, 0);
        handshake0(16'd3);

        // 4: backpressure with new operands presented while DONE
        drive0(64'd10, 64'd20, 1'b1, 1'b0);
        tick();
        bus0.in_valid = 0;
        repeat (2) tick();
        chk("t4_sum", bus0.out_sum, 64'd31);
        drive0(64'd1, 64'd1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_stall_valid", bus0.out_valid, 1);
            chk("t4_stall_sum", bus0.out_sum, 64'd31);
            chk("t4_stall_add_a", bus0.add_a, 64'd10);
            chk("t4_stall_add_b", bus0.add_b, 64'd20);
            chk("t4_stall_count", op_count0, 3);
            chk("t4_stall_in_ready", bus0.in_ready, 0);
        end
        bus0.in_valid = 0;
        handshake0(16'd4);
        chk("t4_add_a_kept", bus0.add_a, 64'd10);

        // 5: reset one cycle after accept
        drive0(64'd3, 64'd4, 1'b0, 1'b0);
        tick();
        bus0.in_valid = 0;
        tick();
        #2;
        rst_n0 = 1'b0;
        #1;
        chk("t5_out_valid", bus0.out_valid, 0);
        chk("t5_op_count", op_count0, 0);
        chk("t5_in_ready", bus0.in_ready, 1);
        chk("t5_add_a", bus0.add_a, 0);
        chk("t5_out_sum", bus0.out_sum, 0);
        tick();
        rst_n0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_stale_valid", bus0.out_valid, 0);
            chk("t5_idle_ready", bus0.in_ready, 1);
        end

        // 6: SETTLE_CYCLES=5, 4-bit counter driven to all-ones then wrapped
        for (int i = 0; i < 15; i++) begin
            bus1.in_a = 64'(i); bus1.in_b = 64'd1; bus1.in_valid = 1;
            tick();
            bus1.in_valid = 0;
            repeat (6) tick();
        end
        chk("t6_count_full", op_count1, 4'hF);
        chk("t6_idle", bus1.in_ready, 1);
        bus1.in_a = 64'd100; bus1.in_b = 64'd23; bus1.in_cin = 0; bus1.in_sub = 0;
        bus1.in_valid = 1;
        tick();
        bus1.in_valid = 0;
        repeat (4) tick();
        chk("t6_valid_at_k4", bus1.out_valid, 0);
        tick();
        chk("t6_valid_at_k5", bus1.out_valid, 1);
        chk("t6_sum", bus1.out_sum, 64'd123);
        tick();
        chk("t6_count_wrap", op_count1, 4'h0);
        chk("t6_done_cleared", bus1.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
